// File: rtl/pwm_plane_spi_master.sv
// pwm_plane_spi_master
// Host-side SPI initiator for the PWM controller. Keeps a shadow copy of every
// channel's duty value; on start it snapshots the shadow file and sends one
// SPI frame per bit plane (plane 0 first), SPI mode 0, MSB first.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   duty_we    shadow write strobe (duty_addr >= NUM_PWM is ignored)
//   duty_addr  channel index
//   duty_data  duty value
//   start      single-cycle request to send all planes (IDLE only)
//   busy       high from the cycle after an accepted start until done
//   done       one-cycle pulse when the last frame's gap ends
//   nCS/SCK/MOSI  registered SPI outputs
//
// state | meaning
// IDLE  | nCS high, waiting for start
// SETUP | nCS low, SCK low, MSB presented
// HIGH  | SCK high, slave samples MOSI
// LOW   | SCK low, next bit presented (or 0 during the hold after the last bit)
// GAP   | nCS high between frames
module pwm_plane_spi_master #(
  parameter int PWM_WIDTH = 16,
  parameter int NUM_PWM   = 12,
  parameter int SPI_WIDTH = 16,
  parameter int SCK_DIV   = 4,
  parameter int CS_GAP    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       duty_we,
  input  logic [$clog2(NUM_PWM)-1:0] duty_addr,
  input  logic [PWM_WIDTH-1:0]       duty_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       nCS,
  output logic                       SCK,
  output logic                       MOSI
);

  localparam int AW      = $clog2(NUM_PWM);
  localparam int PW      = (PWM_WIDTH > 1) ? $clog2(PWM_WIDTH) : 1;
  localparam int BW      = $clog2(SPI_WIDTH + 1);
  localparam int CNT_MAX = (SCK_DIV > CS_GAP) ? SCK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SCK_LOAD   = CW'(SCK_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(CS_GAP - 1);
  localparam logic [PW-1:0] LAST_PLANE = PW'(PWM_WIDTH - 1);
  localparam logic [BW-1:0] BITS_FULL  = BW'(SPI_WIDTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  typedef logic [NUM_PWM-1:0][PWM_WIDTH-1:0] duty_file_t;

  duty_file_t            shadow_q, shadow_d;
  duty_file_t            work_q,   work_d;
  logic [2:0]            state_q,  state_d;
  logic [CW-1:0]         cnt_q,    cnt_d;
  logic [BW-1:0]         bits_q,   bits_d;
  logic [PW-1:0]         plane_q,  plane_d;
  logic [SPI_WIDTH-1:0]  shift_q,  shift_d;
  logic                  ncs_q,    ncs_d;
  logic                  sck_q,    sck_d;
  logic                  mosi_q,   mosi_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;
  logic                  cnt_zero;

  // Transpose: bit i of the frame is bit p of channel i; padding bits stay 0.
  function automatic logic [SPI_WIDTH-1:0] plane_word(input duty_file_t f,
                                                      input logic [PW-1:0] p);
    logic [SPI_WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_PWM; i++) w[i] = f[i][p];
    return w;
  endfunction

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    shadow_d = shadow_q;
    work_d   = work_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    bits_d   = bits_q;
    plane_d  = plane_q;
    shift_d  = shift_q;
    ncs_d    = ncs_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    // Out-of-range addresses match no entry and are dropped.
    for (int i = 0; i < NUM_PWM; i++) begin
      if (duty_we && (duty_addr == AW'(i))) shadow_d[i] = duty_data;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Snapshot uses shadow_q, so a same-cycle write is not included.
          state_d = S_SETUP;
          cnt_d   = SCK_LOAD;
          plane_d = '0;
          work_d  = shadow_q;
          shift_d = plane_word(shadow_q, PW'(0));
          bits_d  = BITS_FULL;
          ncs_d   = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = shift_d[SPI_WIDTH-1];
          busy_d  = 1'b1;
        end
      end
      S_SETUP: begin
        if (!cnt_zero) cnt_d = cnt_q - 1'b1;
        else begin
          state_d = S_HIGH;
          cnt_d   = SCK_LOAD;
          sck_d   = 1'b1;
        end
      end
      S_HIGH: begin
        if (!cnt_zero) cnt_d = cnt_q - 1'b1;
        else begin
          state_d = S_LOW;
          cnt_d   = SCK_LOAD;
          sck_d   = 1'b0;
          bits_d  = bits_q - 1'b1;
          shift_d = shift_q << 1;
          // bits_q == 1 means the bit just sampled was the last: hold MOSI low.
          mosi_d  = (bits_q == BW'(1)) ? 1'b0 : shift_q[SPI_WIDTH-2];
        end
      end
      S_LOW: begin
        if (!cnt_zero) cnt_d = cnt_q - 1'b1;
        else if (bits_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
          ncs_d   = 1'b1;
          mosi_d  = 1'b0;
        end else begin
          state_d = S_HIGH;
          cnt_d   = SCK_LOAD;
          sck_d   = 1'b1;
        end
      end
      S_GAP: begin
        if (!cnt_zero) cnt_d = cnt_q - 1'b1;
        else if (plane_q == LAST_PLANE) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_SETUP;
          cnt_d   = SCK_LOAD;
          plane_d = plane_q + 1'b1;
          shift_d = plane_word(work_q, plane_q + 1'b1);
          bits_d  = BITS_FULL;
          ncs_d   = 1'b0;
          mosi_d  = shift_d[SPI_WIDTH-1];
        end
      end
      default: begin
        state_d = S_IDLE;
        ncs_d   = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
      work_q   <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bits_q   <= '0;
      plane_q  <= '0;
      shift_q  <= '0;
      ncs_q    <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      work_q   <= work_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bits_q   <= bits_d;
      plane_q  <= plane_d;
      shift_q  <= shift_d;
      ncs_q    <= ncs_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign nCS  = ncs_q;
  assign SCK  = sck_q;
  assign MOSI = mosi_q;

endmodule

// File: tb/tb_pwm_plane_spi_master.sv
// Bench for pwm_plane_spi_master: a bench SPI slave captures frames and a
// scoreboard queue holds the expected plane words pushed at each start.
module tb_pwm_plane_spi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        duty_we = 1'b0;
  logic [3:0]  duty_addr = '0;
  logic [15:0] duty_data = '0;
  logic        start = 1'b0;
  logic        busy, done, ncs, sck, mosi;
  logic        busy1, done1, ncs1, sck1, mosi1;

  always #5 clk = ~clk;

  pwm_plane_spi_master dut (
    .clk(clk), .rst(rst), .duty_we(duty_we), .duty_addr(duty_addr),
    .duty_data(duty_data), .start(start), .busy(busy), .done(done),
    .nCS(ncs), .SCK(sck), .MOSI(mosi)
  );

  pwm_plane_spi_master #(.SCK_DIV(1), .CS_GAP(1)) dut_fast (
    .clk(clk), .rst(rst), .duty_we(duty_we), .duty_addr(duty_addr),
    .duty_data(duty_data), .start(start), .busy(busy1), .done(done1),
    .nCS(ncs1), .SCK(sck1), .MOSI(mosi1)
  );

  int check_cnt = 0;
  int pass_cnt  = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] model [12];
  logic [15:0] exp_q [$];
  logic [15:0] rx_log [$];
  int          frames_total = 0;
  int          done_total = 0;
  logic [15:0] rx_sh = '0;
  int          rx_cnt = 0;
  logic        ncs_prev = 1'b1;
  logic        sck_prev = 1'b0;
  int          start_cyc, fb, db;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [15:0] model_plane(input int p);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 12; i++) w[i] = model[i][p];
    return w;
  endfunction

  // Reassemble channel i from the 16 frames of the latest transfer.
  function automatic logic [15:0] rx_duty(input int i);
    logic [15:0] v;
    logic [15:0] f;
    v = '0;
    for (int p = 0; p < 16; p++) begin
      f = rx_log[fb + p];
      v[p] = f[i];
    end
    return v;
  endfunction

  // Bench SPI slave: samples MOSI after each SCK rise, frame ends on nCS rise.
  always @(negedge clk) begin
    if (!rst) begin
      rx_cnt   = 0;
      rx_sh    = '0;
      ncs_prev = 1'b1;
      sck_prev = 1'b0;
    end else begin
      if (!ncs && !sck_prev && sck) begin
        rx_sh = {rx_sh[14:0], mosi};
        rx_cnt++;
      end
      if (ncs && !ncs_prev) begin
        check("frame_bits", rx_cnt, 16);
        if (exp_q.size() == 0) begin
          check_cnt++;
          $display("FAIL unexpected_frame: got 0x%0h expected no frame", rx_sh);
        end else check("frame_data", rx_sh, exp_q.pop_front());
        rx_log.push_back(rx_sh);
        frames_total++;
        rx_cnt = 0;
      end
      if (done) done_total++;
      ncs_prev = ncs;
      sck_prev = sck;
    end
  end

  task automatic write_duty(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    duty_we = 1'b1; duty_addr = a; duty_data = d;
    @(negedge clk);
    duty_we = 1'b0;
    if (a < 12) model[a] = d;
  endtask

  task automatic do_start(input bit wr, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    for (int p = 0; p < 16; p++) exp_q.push_back(model_plane(p));
    fb = frames_total;
    db = done_total;
    start = 1'b1;
    if (wr) begin duty_we = 1'b1; duty_addr = a; duty_data = d; end
    @(posedge clk); #1;
    start = 1'b0; duty_we = 1'b0;
    start_cyc = cyc;
    if (wr && a < 12) model[a] = d;
    check("start_busy", busy, 1);
    check("start_ncs", ncs, 0);
  endtask

  task automatic wait_done();
    int n;
    n = -1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (done) begin n = cyc - start_cyc; break; end
    end
    check("done_cycles", n, 2144);
    check("busy_at_done", busy, 0);
    @(negedge clk); #1;
    check("frame_count", frames_total - fb, 16);
    check("done_pulses", done_total - db, 1);
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    logic [15:0] p0;
    logic [15:0] p15;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl [4];
    int n, m, r, db2;
    logic sp;
    logic [15:0] hi;

    tbl[0] = '{4'd0,  16'h0001, 16'h0001, 16'h0000};
    tbl[1] = '{4'd11, 16'h8000, 16'h0001, 16'h0800};
    tbl[2] = '{4'd12, 16'hFFFF, 16'h0001, 16'h0800};
    tbl[3] = '{4'd5,  16'hFFFF, 16'h0021, 16'h0820};
    for (int i = 0; i < 12; i++) model[i] = '0;

    // Reset values
    repeat (3) @(posedge clk); #1;
    check("rst_ncs", ncs, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk) rst = 1'b1;

    // Reset mid-frame: aborts without done, clears the shadow file
    write_duty(4'd2, 16'hABCD);
    do_start(0, '0, '0);
    repeat (300) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 12; i++) model[i] = '0;
    db2 = done_total;
    #1;
    check("midrst_ncs", ncs, 1);
    check("midrst_sck", sck, 0);
    check("midrst_mosi", mosi, 0);
    check("midrst_busy", busy, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("midrst_idle_busy", busy, 0);
    check("midrst_idle_ncs", ncs, 1);
    check("midrst_no_done", done_total - db2, 0);

    // All-zero transfer; fast instance timing (sck_div=1, cs_gap=1)
    do_start(0, '0, '0);
    n = 0; r = 0; sp = sck1;
    while (ncs1 == 1'b0 && n < 200) begin
      @(posedge clk); #1; n++;
      if (sck1 && !sp) r++;
      sp = sck1;
    end
    m = 0;
    while (ncs1 == 1'b1 && m < 200) begin
      @(posedge clk); #1; m++;
    end
    check("fast_ncs_low", n, 33);
    check("fast_sck_rises", r, 16);
    check("fast_period", n + m, 34);
    wait_done();

    // Table-driven single writes, each followed by a full transfer
    for (int t = 0; t < 4; t++) begin
      write_duty(tbl[t].addr, tbl[t].data);
      do_start(0, '0, '0);
      wait_done();
      check("tbl_plane0", rx_log[fb], tbl[t].p0);
      check("tbl_plane15", rx_log[fb + 15], tbl[t].p15);
    end

    // Bench-slave decode of all channels
    for (int i = 0; i < 12; i++) write_duty(4'(i), 16'(32'h1111 * (i + 1)));
    do_start(0, '0, '0);
    wait_done();
    for (int i = 0; i < 12; i++) check("decode", rx_duty(i), 16'(32'h1111 * (i + 1)));
    hi = '0;
    for (int p = 0; p < 16; p++) hi = hi | (rx_log[fb + p] & 16'hF000);
    check("pad_bits", hi, 0);

    // Snapshot isolation
    do_start(0, '0, '0);
    while (cyc < start_cyc + 500) @(posedge clk);
    write_duty(4'd3, 16'hFFFF);
    wait_done();
    check("snap_old", rx_duty(3), 16'h4444);
    do_start(0, '0, '0);
    wait_done();
    check("snap_new", rx_duty(3), 16'hFFFF);

    // Same-cycle start+write, and a start while busy
    do_start(1, 4'd1, 16'h0F0F);
    while (cyc < start_cyc + 1000) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done();
    check("same_cycle_old", rx_duty(1), 16'h2222);
    repeat (20) @(posedge clk); #1;
    check("no_queued_busy", busy, 0);
    check("no_queued_ncs", ncs, 1);
    do_start(0, '0, '0);
    wait_done();
    check("same_cycle_new", rx_duty(1), 16'h0F0F);
    check("exp_q_empty", exp_q.size(), 0);
    check("fast_idle_busy", busy1, 0);
    check("fast_idle_done", done1, 0);
    check("fast_idle_mosi", mosi1, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
